// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: round-robin arbiter that shares one downstream APB bus
// between several core-side APB master ports. It owns the downstream
// SETUP/ACCESS sequencing itself and has a PREADY watchdog so that a hung
// slave cannot stall every core indefinitely.
module apb_rr_arbiter #(
    parameter int BUS_WIDTH      = 16,
    parameter int MASTER_PORTS   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
    input  logic [MASTER_PORTS-1:0]           S_PWRITE,
    input  logic [MASTER_PORTS-1:0]           S_PSELx,
    input  logic [MASTER_PORTS-1:0]           S_PENABLE,
    input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
    output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
    output logic [MASTER_PORTS-1:0]           S_PREADY,
    output logic [BUS_WIDTH-1:0]              M_PADDR,
    output logic                              M_PWRITE,
    output logic                              M_PSEL,
    output logic                              M_PENABLE,
    output logic [BUS_WIDTH-1:0]              M_PWDATA,
    input  logic [BUS_WIDTH-1:0]              M_PRDATA,
    input  logic                              M_PREADY,
    output logic [MASTER_PORTS-1:0]           grant,
    output logic                              timeout_err
);

    localparam int IDX_W      = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;
    localparam int WD_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int WD_MAX_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [WD_W-1:0]         WD_MAX  = WD_W'(WD_MAX_INT);
    localparam logic [MASTER_PORTS-1:0] ONE_HOT = MASTER_PORTS'(1);
    localparam logic [IDX_W-1:0]        LAST_RST = IDX_W'(MASTER_PORTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  g;
    logic [IDX_W-1:0]  last;
    logic [IDX_W-1:0]  next_g;
    logic              found;
    logic [WD_W-1:0]   wd_cnt;
    logic              timed_out;
    logic              done;

    // Core-side PENABLE is observed only; arbitration keys purely off PSEL.
    logic unused_penable;
    assign unused_penable = ^S_PENABLE;

    // Candidate index k steps after the previous owner, wrapping around.
    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int k);
        int sum;
        sum = (int'(base) + 1 + k) % MASTER_PORTS;
        return sum[IDX_W-1:0];
    endfunction

    // Round-robin search for the first requesting core after the last owner.
    always_comb begin
        next_g = '0;
        found  = 1'b0;
        for (int k = 0; k < MASTER_PORTS; k++) begin
            if (!found && S_PSELx[rr_index(last, k)]) begin
                next_g = rr_index(last, k);
                found  = 1'b1;
            end
        end
    end

    // Transfer ends on slave ready, or when the watchdog runs out first.
    always_comb begin
        timed_out = (TIMEOUT_CYCLES != 0) && (state == ACCESS) && !M_PREADY && (wd_cnt == WD_MAX);
        done      = (state == ACCESS) && (M_PREADY || timed_out);
    end

    // Main FSM: arbitrate in IDLE, then hold the grant through SETUP and ACCESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            g           <= '0;
            last        <= LAST_RST;
            grant       <= '0;
            M_PSEL      <= 1'b0;
            M_PENABLE   <= 1'b0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        g      <= next_g;
                        grant  <= ONE_HOT << next_g;
                        M_PSEL <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    M_PENABLE <= 1'b1;
                    wd_cnt    <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        last      <= g;
                        wd_cnt    <= '0;
                        grant     <= '0;
                        M_PSEL    <= 1'b0;
                        M_PENABLE <= 1'b0;
                        state     <= IDLE;
                        if (timed_out) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Downstream address/control/data follow the owning core while the bus is held.
    always_comb begin
        M_PADDR  = '0;
        M_PWRITE = 1'b0;
        M_PWDATA = '0;
        if (M_PSEL) begin
            M_PADDR  = S_PADDR[int'(g)*BUS_WIDTH +: BUS_WIDTH];
            M_PWRITE = S_PWRITE[g];
            M_PWDATA = S_PWDATA[int'(g)*BUS_WIDTH +: BUS_WIDTH];
        end
    end

    // Completion is returned only to the owner; a timeout returns all-ones data.
    always_comb begin
        S_PREADY = '0;
        S_PRDATA = '0;
        if (done) begin
            S_PREADY[g] = 1'b1;
            S_PRDATA[int'(g)*BUS_WIDTH +: BUS_WIDTH] = timed_out ? {BUS_WIDTH{1'b1}} : M_PRDATA;
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb_apb_rr_arbiter: directed stimulus against apb_rr_arbiter with a
// transaction-level reference model checked on every cycle, plus literal
// expectations at the interesting points of each scenario.
module tb_apb_rr_arbiter;

    localparam int BW = 16;
    localparam int N  = 4;
    localparam int TO = 8;

    logic              clk;
    logic              reset;
    logic [N*BW-1:0]   s_paddr;
    logic [N-1:0]      s_pwrite;
    logic [N-1:0]      s_psel;
    logic [N-1:0]      s_penable;
    logic [N*BW-1:0]   s_pwdata;
    logic [N*BW-1:0]   s_prdata;
    logic [N-1:0]      s_pready;
    logic [BW-1:0]     m_paddr;
    logic              m_pwrite;
    logic              m_psel;
    logic              m_penable;
    logic [BW-1:0]     m_pwdata;
    logic [BW-1:0]     slave_rdata;
    logic              m_pready;
    logic [N-1:0]      grant;
    logic              timeout_err;

    int n_checks = 0;
    int n_fails  = 0;

    // slave_wait < 0 means the slave never answers
    int slave_wait;
    int acc_cnt;

    apb_rr_arbiter #(
        .BUS_WIDTH(BW),
        .MASTER_PORTS(N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .S_PADDR(s_paddr),
        .S_PWRITE(s_pwrite),
        .S_PSELx(s_psel),
        .S_PENABLE(s_penable),
        .S_PWDATA(s_pwdata),
        .S_PRDATA(s_prdata),
        .S_PREADY(s_pready),
        .M_PADDR(m_paddr),
        .M_PWRITE(m_pwrite),
        .M_PSEL(m_psel),
        .M_PENABLE(m_penable),
        .M_PWDATA(m_pwdata),
        .M_PRDATA(slave_rdata),
        .M_PREADY(m_pready),
        .grant(grant),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reactive slave: answers after slave_wait ACCESS cycles.
    always @(posedge clk or posedge reset) begin
        if (reset) acc_cnt <= 0;
        else if (!m_penable) acc_cnt <= 0;
        else acc_cnt <= acc_cnt + 1;
    end
    assign m_pready = m_penable && (slave_wait >= 0) && (acc_cnt >= slave_wait);

    // ---------------- reference model ----------------
    int mdl_owner;
    bit mdl_setup;
    int mdl_acc;
    int mdl_last;
    bit mdl_err;

    function automatic int rr_pick(input int last_owner, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(last_owner + k) % N]) return (last_owner + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdl_owner <= -1;
            mdl_setup <= 1'b0;
            mdl_acc   <= 0;
            mdl_last  <= N - 1;
            mdl_err   <= 1'b0;
        end else if (mdl_owner < 0) begin
            if (rr_pick(mdl_last, s_psel) >= 0) begin
                mdl_owner <= rr_pick(mdl_last, s_psel);
                mdl_setup <= 1'b1;
            end
        end else if (mdl_setup) begin
            mdl_setup <= 1'b0;
            mdl_acc   <= 0;
        end else if (m_pready) begin
            mdl_last  <= mdl_owner;
            mdl_owner <= -1;
        end else if (TO != 0 && mdl_acc == TO - 1) begin
            mdl_err   <= 1'b1;
            mdl_last  <= mdl_owner;
            mdl_owner <= -1;
        end else begin
            mdl_acc <= mdl_acc + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    logic [N-1:0]    e_grant;
    logic [N-1:0]    e_sready;
    logic [N*BW-1:0] e_prdata;
    logic [BW-1:0]   e_addr;
    logic [BW-1:0]   e_wdata;
    logic            e_write;
    logic            e_psel;
    logic            e_pen;
    logic            e_done;

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        e_grant  = '0;
        e_sready = '0;
        e_prdata = '0;
        e_addr   = '0;
        e_wdata  = '0;
        e_write  = 1'b0;
        e_psel   = 1'b0;
        e_pen    = 1'b0;
        e_done   = 1'b0;
        if (mdl_owner >= 0) begin
            e_psel = 1'b1;
            e_pen  = !mdl_setup;
            e_grant[mdl_owner] = 1'b1;
            e_addr  = s_paddr[mdl_owner*BW +: BW];
            e_wdata = s_pwdata[mdl_owner*BW +: BW];
            e_write = s_pwrite[mdl_owner];
            e_done  = e_pen && (m_pready || (TO != 0 && mdl_acc == TO - 1));
            if (e_done) begin
                e_sready[mdl_owner] = 1'b1;
                e_prdata[mdl_owner*BW +: BW] = m_pready ? slave_rdata : {BW{1'b1}};
            end
        end
        checkOutput("mdl_grant", grant, e_grant);
        checkOutput("mdl_psel", m_psel, e_psel);
        checkOutput("mdl_penable", m_penable, e_pen);
        checkOutput("mdl_paddr", m_paddr, e_addr);
        checkOutput("mdl_pwrite", m_pwrite, e_write);
        checkOutput("mdl_pwdata", m_pwdata, e_wdata);
        checkOutput("mdl_spready", s_pready, e_sready);
        checkOutput("mdl_sprdata", s_prdata, e_prdata);
        checkOutput("mdl_timeout_err", timeout_err, mdl_err);
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int core, input logic [BW-1:0] addr, input logic wr, input logic [BW-1:0] wdata);
        s_paddr[core*BW +: BW]  = addr;
        s_pwdata[core*BW +: BW] = wdata;
        s_pwrite[core]          = wr;
        s_psel[core]            = 1'b1;
        s_penable[core]         = 1'b0;
    endtask

    // Waits (bounded) for the core's ready pulse, then withdraws its request.
    task automatic wait_done(input int core, input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (s_pready[core]) seen = 1'b1;
        end
        checkOutput($sformatf("done_core%0d", core), seen, 1'b1);
        next_cycle();
        s_psel[core]    = 1'b0;
        s_penable[core] = 1'b0;
    endtask

    logic [N-1:0] exp4;

    initial begin
        reset       = 1'b0;
        s_paddr     = '0;
        s_pwrite    = '0;
        s_psel      = '0;
        s_penable   = '0;
        s_pwdata    = '0;
        slave_rdata = '0;
        slave_wait  = 0;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_psel", m_psel, 0);
        checkOutput("rst_penable", m_penable, 0);
        checkOutput("rst_spready", s_pready, 0);
        checkOutput("rst_err", timeout_err, 0);

        // Single read by core 2
        slave_rdata = 16'h1234;
        applyStimulus(2, 16'h0080, 1'b0, 16'h0000);
        next_cycle();
        checkOutput("t1_setup_psel", m_psel, 1);
        checkOutput("t1_setup_penable", m_penable, 0);
        checkOutput("t1_setup_grant", grant, 4'b0100);
        checkOutput("t1_setup_addr", m_paddr, 16'h0080);
        next_cycle();
        checkOutput("t1_access_penable", m_penable, 1);
        checkOutput("t1_access_spready", s_pready, 4'b0100);
        checkOutput("t1_access_sprdata", s_prdata, {16'h0000, 16'h1234, 32'h0000_0000});
        s_psel[2] = 1'b0;
        next_cycle();
        checkOutput("t1_idle_psel", m_psel, 0);
        checkOutput("t1_idle_spready", s_pready, 0);

        // All four cores requesting continuously from a fresh reset
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        slave_rdata = 16'hC0DE;
        for (int i = 0; i < N; i++) applyStimulus(i, 16'h0100 + 16'(i), 1'b0, 16'h0000);
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            exp4 = 4'b0001 << (k % 4);
            checkOutput($sformatf("t2_grant_%0d", k), grant, exp4);
            checkOutput($sformatf("t2_addr_%0d", k), m_paddr, 16'h0100 + 16'(k % 4));
            next_cycle();
            next_cycle();
        end
        s_psel = '0;

        // Make core 1 the last owner, then cores 1 and 3 contend
        applyStimulus(1, 16'h0040, 1'b0, 16'h0000);
        wait_done(1, 10);
        slave_rdata = 16'h3333;
        applyStimulus(3, 16'h0030, 1'b0, 16'h0000);
        applyStimulus(1, 16'h00A0, 1'b1, 16'hBEEF);
        next_cycle();
        checkOutput("t3_first_grant", grant, 4'b1000);
        next_cycle();
        checkOutput("t3_first_spready", s_pready, 4'b1000);
        s_psel[3] = 1'b0;
        next_cycle();
        checkOutput("t3_gap_grant", grant, 0);
        next_cycle();
        checkOutput("t3_second_grant", grant, 4'b0010);
        checkOutput("t3_setup_addr", m_paddr, 16'h00A0);
        checkOutput("t3_setup_write", m_pwrite, 1);
        checkOutput("t3_setup_wdata", m_pwdata, 16'hBEEF);
        next_cycle();
        checkOutput("t3_access_wdata", m_pwdata, 16'hBEEF);
        checkOutput("t3_access_spready", s_pready, 4'b0010);
        s_psel[1]   = 1'b0;
        s_pwrite[1] = 1'b0;
        next_cycle();

        // Slow slave: 5 wait states, cores 0 and 2 waiting (last = 1)
        slave_wait  = 5;
        slave_rdata = 16'h4444;
        applyStimulus(0, 16'h0011, 1'b0, 16'h0000);
        applyStimulus(2, 16'h0022, 1'b0, 16'h0000);
        next_cycle();
        checkOutput("t4_grant", grant, 4'b0100);
        for (int a = 1; a <= 5; a++) begin
            next_cycle();
            checkOutput($sformatf("t4_wait%0d_spready", a), s_pready, 0);
            checkOutput($sformatf("t4_wait%0d_penable", a), m_penable, 1);
        end
        next_cycle();
        checkOutput("t4_ready_spready", s_pready, 4'b0100);
        checkOutput("t4_ready_sprdata", s_prdata, {16'h0000, 16'h4444, 32'h0000_0000});
        s_psel[2] = 1'b0;
        wait_done(0, 20);

        // Hung slave: watchdog completes the transfer after 8 ACCESS cycles
        slave_wait = -1;
        applyStimulus(3, 16'h0033, 1'b0, 16'h0000);
        next_cycle();
        checkOutput("t5_grant", grant, 4'b1000);
        for (int a = 1; a <= 7; a++) begin
            next_cycle();
            checkOutput($sformatf("t5_hang%0d_spready", a), s_pready, 0);
        end
        next_cycle();
        checkOutput("t5_to_spready", s_pready, 4'b1000);
        checkOutput("t5_to_sprdata", s_prdata, {16'hFFFF, 48'h0});
        checkOutput("t5_to_err_before", timeout_err, 0);
        s_psel[3] = 1'b0;
        next_cycle();
        checkOutput("t5_err_set", timeout_err, 1);
        checkOutput("t5_idle_psel", m_psel, 0);
        slave_wait  = 0;
        slave_rdata = 16'h5A5A;
        applyStimulus(1, 16'h0050, 1'b0, 16'h0000);
        next_cycle();
        next_cycle();
        checkOutput("t5_next_spready", s_pready, 4'b0010);
        checkOutput("t5_next_sprdata", s_prdata, {32'h0000_0000, 16'h5A5A, 16'h0000});
        s_psel[1] = 1'b0;
        next_cycle();
        checkOutput("t5_err_sticky", timeout_err, 1);

        // Reset in the middle of ACCESS
        slave_wait = -1;
        applyStimulus(2, 16'h0077, 1'b0, 16'h0000);
        next_cycle();
        next_cycle();
        next_cycle();
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_psel", m_psel, 0);
        checkOutput("t6_rst_penable", m_penable, 0);
        checkOutput("t6_rst_grant", grant, 0);
        checkOutput("t6_rst_spready", s_pready, 0);
        checkOutput("t6_rst_err", timeout_err, 0);
        s_psel = '0;
        next_cycle();
        reset      = 1'b0;
        slave_wait = 0;
        applyStimulus(3, 16'h0003, 1'b0, 16'h0000);
        applyStimulus(0, 16'h0000, 1'b0, 16'h0000);
        next_cycle();
        checkOutput("t6_first_grant", grant, 4'b0001);
        next_cycle();
        s_psel[0] = 1'b0;
        next_cycle();
        next_cycle();
        checkOutput("t6_second_grant", grant, 4'b1000);
        next_cycle();
        s_psel[3] = 1'b0;
        repeat (3) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- Multi-master APB arbiter placed between the per-core APB master ports and the shared APB address decoder/interconnect.
- Grants the single downstream APB bus to one core at a time using round-robin fairness.
- Holds the grant for the full transfer (SETUP, then ACCESS until PREADY), and generates the downstream APB phases itself.
- Includes a PREADY watchdog so a hung slave cannot stall every core indefinitely.

Parameters:
- BUS_WIDTH, 16, width of address and data buses.
- MASTER_PORTS, 4, number of requesting cores (≥2).
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before forced completion; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- S_PADDR  in  MASTER_PORTS*BUS_WIDTH  per-core address, core i at [i*BUS_WIDTH +: BUS_WIDTH]
- S_PWRITE  in  MASTER_PORTS  per-core write flag
- S_PSELx  in  MASTER_PORTS  per-core request (APB PSEL)
- S_PENABLE  in  MASTER_PORTS  per-core PENABLE (monitored only)
- S_PWDATA  in  MASTER_PORTS*BUS_WIDTH  per-core write data
- S_PRDATA  out  MASTER_PORTS*BUS_WIDTH  per-core read data
- S_PREADY  out  MASTER_PORTS  per-core ready
- M_PADDR  out  BUS_WIDTH  downstream address
- M_PWRITE  out  1  downstream write
- M_PSEL  out  1  downstream select (the decoder expands it to slave PSELx)
- M_PENABLE  out  1  downstream enable
- M_PWDATA  out  BUS_WIDTH  downstream write data
- M_PRDATA  in  BUS_WIDTH  downstream read data
- M_PREADY  in  1  downstream ready
- grant  out  MASTER_PORTS  one-hot current owner; zero when idle
- timeout_err  out  1  sticky flag, set on a watchdog expiry

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, grant=0, grant index g=0, last=MASTER_PORTS-1 (so core 0 has first priority).
  - Watchdog counter=0, timeout_err=0.
  - All M_* outputs and all S_PREADY/S_PRDATA = 0.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - All outputs 0 except timeout_err.
  - If |S_PSELx, select the first asserted core searching last+1, last+2, … modulo MASTER_PORTS.
  - Register g and the one-hot grant, then go to SETUP.
  - Requests are sampled only in IDLE.
- SETUP (exactly 1 cycle):
  - M_PSEL=1, M_PENABLE=0.
  - M_PADDR/M_PWRITE/M_PWDATA = core g's inputs (combinational mux on registered g).
  - Go to ACCESS.
- ACCESS:
  - M_PSEL=1, M_PENABLE=1, same address/data mux.
  - Watchdog increments each cycle.
  - If M_PREADY=1: S_PREADY[g]=1 and S_PRDATA[g]=M_PRDATA for that cycle only; last=g; clear watchdog; go to IDLE.
  - Else if TIMEOUT_CYCLES≠0 and watchdog reaches TIMEOUT_CYCLES-1 without M_PREADY: S_PREADY[g]=1, S_PRDATA[g]={BUS_WIDTH{1'b1}}, timeout_err←1; last=g; clear watchdog; go to IDLE.
- Non-granted cores always see S_PREADY=0 and S_PRDATA=0; they remain stalled in their own ACCESS phase.
- Minimum cost is 3 cycles per transfer (IDLE, SETUP, ACCESS). There is always one IDLE cycle between transfers, in which re-arbitration happens.
- Grant is locked: a change in S_PSELx/S_PENABLE during SETUP or ACCESS does not alter g or abort the transfer. A granted core dropping PSEL mid-transfer is a protocol violation; the transfer still completes.
- A core that deasserts PSEL before being granted loses its place with no side effects.
- Single requester: that core is granted every time, regardless of last.
- timeout_err clears only on reset.
- Reset mid-ACCESS: the bus is released immediately and no S_PREADY pulse is issued.

Test Plan:
- Single read, core 2, addr 16'h0080, slave returns 16'h1234 with M_PREADY in first ACCESS cycle -> M_PSEL rises at cycle 1, M_PENABLE at cycle 2; S_PREADY[2] pulses 1 cycle with S_PRDATA[2]=16'h1234; grant=4'b0100 during SETUP/ACCESS.
- All 4 cores hold PSEL continuously, zero-wait slave -> grant sequence 0,1,2,3,0,… with one transfer every 3 cycles; no core is serviced twice before the others.
- Cores 1 and 3 request with last=1 -> core 3 granted first, then core 1; core 1 writes 16'hBEEF to 16'h00A0 and M_PWDATA=16'hBEEF is held through SETUP/ACCESS.
- Slave holds M_PREADY=0 for 5 cycles -> M_PSEL/M_PENABLE held; only the granted core sees PREADY, on cycle 6 of ACCESS; others stay stalled.
- TIMEOUT_CYCLES=8, slave never ready -> after 8 ACCESS cycles S_PREADY[g]=1, S_PRDATA[g]=16'hFFFF, timeout_err=1 and stays 1; the next request is served normally.
- Assert reset during ACCESS -> M_PSEL, M_PENABLE, grant and all S_PREADY drop to 0 in the same cycle; after release, core 0 has top priority.
